// File: rtl/prog_tc_counter.sv
// ---------------------------------------------------------------------------
// prog_tc_counter
//   Programmable terminal-count counter used as an event/interval timer.
//   A start pulse (en) captures the terminal value and mode, then count walks
//   from 0 up to term_reg. tc pulses for one cycle when count reaches
//   term_reg. In one-shot mode the run then ends and done is set. In
//   auto-reload mode count returns to 0 and the run continues.
//
// Parameters
//   WIDTH    counter / terminal value width (>= 2)
//   PRESC_W  prescaler width (only meaningful when PRESC_EN is defined)
//
// Configuration macro
//   PRESC_EN  when defined, adds the presc input. count then advances once
//             every presc_reg+1 clk cycles. When the macro is undefined,
//             count advances every cycle.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset, highest priority
//   en        start / retrigger pulse
//   stop      abort a run (ignored when idle, wins over en)
//   mode      0 = one-shot, 1 = auto-reload (captured at start)
//   term_val  terminal count (captured at start)
//   presc     prescale divisor minus one (PRESC_EN only, captured at start)
//   count     current count
//   busy      high while a run is active
//   tc        one-cycle terminal-count pulse
//   done      sticky one-shot completion flag, cleared by start or reset
// ---------------------------------------------------------------------------
module prog_tc_counter #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   term_val,
`ifdef PRESC_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tc,
    output logic               done
);

    // Reject nonsensical configurations at elaboration time.
    if (WIDTH < 2 || PRESC_W < 1) begin : g_param_check
        $error("prog_tc_counter: WIDTH must be >= 2 and PRESC_W >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] term_reg;
    logic             mode_reg;

    logic [WIDTH-1:0] count_inc;
    logic             at_term;
    logic             start;
    logic             tick;

    assign count_inc = count + CNT_ONE;
    assign at_term   = (count == term_reg);

    // stop only matters while running; in that case it overrides en.
    assign start = en && !((state == RUN) && stop);

`ifdef PRESC_EN
    localparam logic [PRESC_W-1:0] PRE_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_reg;
    logic [PRESC_W-1:0] presc_cnt;

    // tick marks the last clk cycle spent at the current count value.
    assign tick = (presc_cnt == presc_reg);
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            term_reg <= '0;
            mode_reg <= 1'b0;
            busy     <= 1'b0;
            tc       <= 1'b0;
            done     <= 1'b0;
`ifdef PRESC_EN
            presc_reg <= '0;
            presc_cnt <= '0;
`endif
        end else if (start) begin
            // Start from idle or retrigger mid-run: identical behaviour.
            state    <= RUN;
            count    <= '0;
            term_reg <= term_val;
            mode_reg <= mode;
            busy     <= 1'b1;
            done     <= 1'b0;
            // A zero terminal value is already at terminal on the first cycle.
            tc       <= (term_val == '0);
`ifdef PRESC_EN
            presc_reg <= presc;
            presc_cnt <= '0;
`endif
        end else if (state == RUN) begin
            if (stop) begin
                // Abort: count holds, done is left as it was.
                state <= IDLE;
                busy  <= 1'b0;
                tc    <= 1'b0;
`ifdef PRESC_EN
                presc_cnt <= '0;
`endif
            end else if (tick) begin
`ifdef PRESC_EN
                presc_cnt <= '0;
`endif
                if (at_term) begin
                    if (!mode_reg) begin
                        // One-shot completion; count stays at term_reg.
                        state <= IDLE;
                        busy  <= 1'b0;
                        tc    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Auto-reload. With term_reg == 0 every cycle is
                        // terminal, so tc stays high.
                        count <= '0;
                        tc    <= (term_reg == '0);
                    end
                end else begin
                    count <= count_inc;
                    tc    <= (count_inc == term_reg);
                end
            end else begin
                // Between prescale ticks count holds and tc is only allowed
                // in the first cycle at the terminal value.
                tc <= 1'b0;
`ifdef PRESC_EN
                presc_cnt <= presc_cnt + PRE_ONE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_tc_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_tc_counter
//   Self-checking bench for prog_tc_counter (WIDTH=16). Each stimulus step
//   pushes the outputs expected after the next rising edge onto a queue. A
//   monitor on the falling edge pops due entries and compares them.
// ---------------------------------------------------------------------------
module tb_prog_tc_counter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         stop;
    logic         mode;
    logic [W-1:0] term_val;
`ifdef PRESC_EN
    logic [7:0]   presc;
`endif
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    prog_tc_counter #(.WIDTH(W), .PRESC_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .stop     (stop),
        .mode     (mode),
        .term_val (term_val),
`ifdef PRESC_EN
        .presc    (presc),
`endif
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        string        name;
        logic [W-1:0] count;
        logic         busy;
        logic         tc;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare every expectation that has come due.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".count"}, 32'(count), 32'(e.count));
            chk({e.name, ".busy"},  32'(busy),  32'(e.busy));
            chk({e.name, ".tc"},    32'(tc),    32'(e.tc));
            chk({e.name, ".done"},  32'(done),  32'(e.done));
        end
    end

    // Drive one cycle of inputs and optionally queue the expected outputs
    // after the coming rising edge. Called just after a rising edge.
    task automatic step(input logic e_n, input logic s, input logic m,
                        input logic [W-1:0] tv, input logic do_chk,
                        input logic [W-1:0] ec, input logic eb,
                        input logic et, input logic ed, input string name);
        exp_t x;
        en       = e_n;
        stop     = s;
        mode     = m;
        term_val = tv;
        if (do_chk) begin
            x.due   = cyc + 1;
            x.name  = name;
            x.count = ec;
            x.busy  = eb;
            x.tc    = et;
            x.done  = ed;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        stop     = 1'b0;
        mode     = 1'b0;
        term_val = 16'd5;
`ifdef PRESC_EN
        presc    = 8'd0;
`endif
        @(posedge clk);
        #1;

        // Reset with en held high: stays idle.
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, "rst0");
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, "rst1");
        reset = 1'b0;
        step(0, 0, 0, 5, 1, 0, 0, 0, 0, "idle0");
        step(0, 0, 0, 5, 1, 0, 0, 0, 0, "idle1");

        // One-shot, term 5. term/mode change mid-run must be ignored.
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, "os_start");
        for (int i = 1; i <= 5; i++)
            step(0, 0, 1, 9, 1, W'(i), 1, (i == 5), 0, "os_run");
        step(0, 0, 0, 9, 1, 5, 0, 0, 1, "os_done");
        step(0, 0, 0, 9, 1, 5, 0, 0, 1, "os_hold");

        // Auto-reload, term 3: period 4.
        step(1, 0, 1, 3, 1, 0, 1, 0, 0, "ar_start");
        for (int i = 1; i <= 20; i++)
            step(0, 0, 1, 3, 1, W'(i % 4), 1, ((i % 4) == 3), 0, "ar_run");
        step(0, 1, 1, 3, 1, 0, 0, 0, 0, "ar_stop");

        // term 0, one-shot.
        step(1, 0, 0, 0, 1, 0, 1, 1, 0, "t0os_start");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, "t0os_done");

        // term 0, auto-reload: tc held high.
        step(1, 0, 1, 0, 1, 0, 1, 1, 0, "t0ar_start");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 1, 0, 1, 1, 0, "t0ar_run");
        step(0, 1, 1, 0, 1, 0, 0, 0, 0, "t0ar_stop");

        // Retrigger at count 2.
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, "rt_start");
        step(0, 0, 0, 5, 1, 1, 1, 0, 0, "rt_run");
        step(0, 0, 0, 5, 1, 2, 1, 0, 0, "rt_run");
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, "rt_retrig");
        for (int i = 1; i <= 5; i++)
            step(0, 0, 0, 5, 1, W'(i), 1, (i == 5), 0, "rt_after");
        step(0, 0, 0, 5, 1, 5, 0, 0, 1, "rt_done");

        // Stop at count 3; stop again while idle is ignored.
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, "sp_start");
        for (int i = 1; i <= 3; i++)
            step(0, 0, 0, 5, 1, W'(i), 1, 0, 0, "sp_run");
        step(0, 1, 0, 5, 1, 3, 0, 0, 0, "sp_stop");
        step(0, 1, 0, 5, 1, 3, 0, 0, 0, "sp_idle");

        // stop and en together while running: stop wins.
        step(1, 0, 0, 5, 1, 0, 1, 0, 0, "se_start");
        step(0, 0, 0, 5, 1, 1, 1, 0, 0, "se_run");
        step(1, 1, 0, 5, 1, 1, 0, 0, 0, "se_both");

        // en in the tc cycle: retrigger wins, no completion recorded.
        step(1, 0, 0, 2, 1, 0, 1, 0, 0, "etc_start");
        step(0, 0, 0, 2, 1, 1, 1, 0, 0, "etc_run");
        step(0, 0, 0, 2, 1, 2, 1, 1, 0, "etc_tc");
        step(1, 0, 0, 2, 1, 0, 1, 0, 0, "etc_retrig");
        step(0, 0, 0, 2, 1, 1, 1, 0, 0, "etc_run2");
        step(0, 0, 0, 2, 1, 2, 1, 1, 0, "etc_tc2");
        step(0, 0, 0, 2, 1, 2, 0, 0, 1, "etc_done");

        // Reset mid-run clears everything including a pending tc.
        step(1, 0, 0, 2, 1, 0, 1, 0, 0, "rr_start");
        step(0, 0, 0, 2, 1, 1, 1, 0, 0, "rr_run");
        reset = 1'b1;
        step(0, 0, 0, 2, 1, 0, 0, 0, 0, "rr_reset");
        reset = 1'b0;
        step(0, 0, 0, 2, 1, 0, 0, 0, 0, "rr_idle");

        // Full-range terminal value: no wrap.
        step(1, 0, 0, 16'hFFFF, 1, 0, 1, 0, 0, "ff_start");
        for (int i = 1; i <= 65535; i++)
            step(0, 0, 0, 16'hFFFF, (i >= 65534), W'(i), 1, (i == 65535), 0, "ff_run");
        step(0, 0, 0, 16'hFFFF, 1, 16'hFFFF, 0, 0, 1, "ff_done");

`ifdef PRESC_EN
        // Prescaled one-shot: count steps every 3 cycles.
        presc = 8'd2;
        step(1, 0, 0, 2, 1, 0, 1, 0, 0, "pr_start");
        presc = 8'd0;
        for (int i = 1; i <= 9; i++)
            step(0, 0, 0, 2, 1, (i == 9) ? W'(2) : W'(i / 3), (i < 9),
                 (i == 6), (i == 9), "pr_run");
`endif

        @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
